// File: rtl/queue_pkg.sv
// -----------------------------------------------------------------------------
// queue_pkg
// Shared definitions for the stack and queue storage blocks.
//   DEFAULT_WIDTH : default bits per entry
//   DEFAULT_DEPTH : default number of entries (power of two, >= 2)
//   log2()        : pointer-width derivation, ceil(log2(n))
//   entry_t       : entry type at the default width
// -----------------------------------------------------------------------------
package queue_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;
    localparam int unsigned DEFAULT_DEPTH = 256;

    // ceil(log2(n)); evaluated at elaboration time to size pointers.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    typedef logic [DEFAULT_WIDTH-1:0] entry_t;

endpackage

// File: rtl/queue_mem.sv
// -----------------------------------------------------------------------------
// queue_mem
// DEPTH x WIDTH register file: one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr and the array
// -----------------------------------------------------------------------------
module queue_mem #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A read of the slot being written in the same cycle returns the old
    // contents; the queue relies on this when popping and pushing while full.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_queue.sv
// -----------------------------------------------------------------------------
// fifo_queue
// First-in/first-out buffer built as a circular buffer over queue_mem, with
// separate read/write pointers and an occupancy counter. The dequeued value
// is held in a register; status pulses last one cycle.
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active low
//   in        : data to enqueue
//   push      : enqueue request
//   pop       : dequeue request
//   out       : most recently dequeued entry (registered)
//   out_valid : pulse, out was updated at the last edge
//   empty     : count == 0 (combinational)
//   full      : count == DEPTH (combinational)
//   count     : number of stored entries
//   overflow  : pulse, a push was rejected because the queue was full
//   underflow : pulse, a pop was rejected because the queue was empty
// -----------------------------------------------------------------------------
module fifo_queue
    import queue_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW   = log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             pop_ok;
    logic             push_ok;
    logic [WIDTH-1:0] rdata;

    // Flags come from the counter only, so pointer equality never has to
    // distinguish full from empty.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // A pop from a full queue frees a slot, so the same-cycle push may use it.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    queue_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        overflow_d  = push & ~push_ok;
        underflow_d = pop & ~pop_ok;

        if (pop_ok) begin
            out_d       = rdata;
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_valid_d = 1'b1;
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
